stopwatch_core: RTL and testbench
=================================

Name: stopwatch_core

Overview:
- BCD stopwatch sitting directly downstream of the 1 kHz→100 Hz divider; samples its 100 Hz square wave (clk_100hz_in) in the clk_in domain and counts centiseconds, seconds and minutes.
- Provides start/stop, lap-freeze and clear control.
- Feeds the 7-segment display mux with six BCD digits plus status flags.

Parameters:
- MAX_MIN, 59: highest minute value (0..99); the count wraps or saturates after MAX_MIN:59.99.
- WRAP, 1: 1 = wrap to 00:00.00 and set overflow; 0 = saturate at the maximum and drop to PAUSE.

Ports:
- clk_in  in  1  system clock, 1 kHz, same clock that drives the divider
- rst_n  in  1  asynchronous, active-low reset
- clk_100hz_in  in  1  100 Hz square wave from the divider, synchronous to clk_in
- btn_start_stop  in  1  debounced level; acts on rising edge
- btn_lap  in  1  debounced level; acts on rising edge
- btn_clear  in  1  debounced level; acts on rising edge
- cs_ones, cs_tens  out  4 each  centisecond BCD digits
- sec_ones, sec_tens  out  4 each  second BCD digits
- min_ones, min_tens  out  4 each  minute BCD digits
- running  out  1  high in RUN or LAP
- lap_active  out  1  high in LAP (display frozen)
- overflow  out  1  sticky; set on wrap or saturation

Behaviour:
- Reset (async, rst_n=0):
  - all counters, lap register and overflow = 0
  - state = IDLE
  - edge-detect registers = 0
  - all outputs 0
- Tick detection:
  - tick = clk_100hz_in & ~prev_100hz, where prev_100hz is a register.
  - One tick every 10 clk_in cycles.
- Button edges: btn_x & ~prev_btn_x; each button has its own prev register.
- Counting:
  - The count advances when tick=1 and the current state register is RUN or LAP.
  - The new value is visible on the next clk_in edge (latency 1).
- BCD cascade:
  - cs 00..99, then sec 00..59, then min 00..MAX_MIN.
  - Carry propagates within the same cycle.
  - Counters never hold a non-BCD value.
- Maximum reached (MAX_MIN:59.99 plus a tick):
  - WRAP=1: next value 00:00.00, overflow set, still running.
  - WRAP=0: value held at the maximum, overflow set, state goes to PAUSE.
- FSM states: IDLE, RUN, LAP, PAUSE.
  - IDLE: start → RUN.
  - RUN: start → PAUSE; lap → LAP, lap_reg loaded with the pre-increment count of that cycle.
  - LAP: lap → RUN (display live); start → PAUSE (display live, lap released).
  - PAUSE: start → RUN; clear → IDLE with count and overflow zeroed.
  - IDLE: clear re-zeroes overflow only.
- Clear handling:
  - Ignored in RUN and LAP.
  - Lap ignored in IDLE and PAUSE.
- Simultaneous button edges: priority clear > start_stop > lap; lower-priority edges in the same cycle are discarded.
- Tick in the same cycle as a stop: the tick counts, because the current state is RUN. Tick in the same cycle as a start from IDLE or PAUSE: not counted.
- Display digits: lap_reg when state == LAP, otherwise the live count. Combinational from registers, no extra latency.
- Buttons held high produce exactly one action per rising edge.
- Reset asserted mid-run: immediate return to all-zero IDLE, with no output glitch beyond the async clear.

Decomposition:
- Shared package stopwatch_pkg:
  - state enum (IDLE=2'd0, RUN=2'd1, LAP=2'd2, PAUSE=2'd3)
  - BCD digit type (4-bit)
  - constants CS_MAX=99, SEC_MAX=59
- Sub-module bcd_digit_counter, instantiated six times:
  - parameter MODULUS
  - ports: en, carry_in, clear, load_max, q[3:0], carry_out
  - the minute-pair wrap is decoded against MAX_MIN in the parent

Test Plan:
- Reset, then start, then 10 clk_100hz_in rising edges (100 clk_in cycles) → 00:00.10, running=1.
- Run to 6000 ticks → 01:00.00. Press start again → PAUSE, digits stable for the next 50 ticks, running=0.
- In RUN at 00:02.37, press lap → digits frozen at 00:02.37, lap_active=1 for 300 ticks. Press lap again → live 00:05.37.
- MAX_MIN=0, WRAP=1: run 6000 ticks → 00:00.00 with overflow=1, still running. Repeat with WRAP=0 → held at 00:59.99, overflow=1, state PAUSE.
- Clear and start rising together in PAUSE → IDLE at 00:00.00 (clear wins). Clear in RUN → no effect.
- Assert rst_n low mid-count at 00:13.45 → all outputs 0 immediately, state IDLE. After release, the first tick without start → still 00:00.00.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the BCD stopwatch.
// State encoding, digit type and the time bundle used across the core.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    LAP   = 2'd2,
    PAUSE = 2'd3
  } state_e;

  typedef logic [3:0] bcd_t;

  localparam int CS_MAX  = 99;
  localparam int SEC_MAX = 59;

  typedef struct packed {
    bcd_t min_t;
    bcd_t min_o;
    bcd_t sec_t;
    bcd_t sec_o;
    bcd_t cs_t;
    bcd_t cs_o;
  } sw_time_t;

  function automatic bcd_t tens_of(int v);
    return bcd_t'(v / 10);
  endfunction

  function automatic bcd_t ones_of(int v);
    return bcd_t'(v % 10);
  endfunction

endpackage

// File: rtl/stopwatch_if.sv
// Control inputs and display outputs of the stopwatch core.
// master drives the 100 Hz wave and buttons; slave is the core.
interface stopwatch_if;
  import stopwatch_pkg::*;

  logic clk_100hz_in;
  logic btn_start_stop;
  logic btn_lap;
  logic btn_clear;
  bcd_t cs_ones;
  bcd_t cs_tens;
  bcd_t sec_ones;
  bcd_t sec_tens;
  bcd_t min_ones;
  bcd_t min_tens;
  logic running;
  logic lap_active;
  logic overflow;

  modport master (
    output clk_100hz_in, btn_start_stop, btn_lap, btn_clear,
    input  cs_ones, cs_tens, sec_ones, sec_tens,
    input  min_ones, min_tens, running, lap_active, overflow
  );

  modport slave (
    input  clk_100hz_in, btn_start_stop, btn_lap, btn_clear,
    output cs_ones, cs_tens, sec_ones, sec_tens,
    output min_ones, min_tens, running, lap_active, overflow
  );

endinterface

// File: rtl/bcd_digit_counter.sv
// One BCD digit with ripple carry; clear beats load_max beats count.
// carry_out flags "this digit and all below are at their last value".
module bcd_digit_counter
  import stopwatch_pkg::*;
#(
  parameter int MODULUS = 10,
  parameter int MAX_Q   = MODULUS - 1
) (
  input  logic clk_in,
  input  logic rst_n,
  input  logic en,
  input  logic carry_in,
  input  logic clear,
  input  logic load_max,
  output bcd_t q,
  output logic carry_out
);

  localparam bcd_t LAST  = bcd_t'(MODULUS - 1);
  localparam bcd_t LOADV = bcd_t'(MAX_Q);

  bcd_t q_q, q_d;
  logic at_last;

  assign at_last   = (q_q == LAST);
  assign carry_out = carry_in & at_last;
  assign q         = q_q;

  always_comb begin
    q_d = q_q;
    if (clear)
      q_d = '0;
    else if (load_max)
      q_d = LOADV;
    else if (en && carry_in)
      q_d = at_last ? '0 : q_q + 4'd1;
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) q_q <= '0;
    else        q_q <= q_d;
  end

endmodule

// File: rtl/stopwatch_core.sv
// BCD stopwatch: 100 Hz tick counting, start/stop, lap freeze, clear.
// Drives six display digits plus running/lap/overflow status.
module stopwatch_core
  import stopwatch_pkg::*;
#(
  parameter int MAX_MIN = 59,
  parameter bit WRAP    = 1'b1
) (
  input  logic       clk_in,
  input  logic       rst_n,
  stopwatch_if.slave sw
);

  state_e   state_q, state_d;
  sw_time_t lap_q, lap_d;
  logic     ovf_q, ovf_d;
  logic     prev_hz_q, prev_ss_q, prev_lap_q, prev_clr_q;

  logic tick, clr_e, ss_e, lap_e;
  logic adv, roll, min_eq, clr_cnt;
  logic cnt_clr, cnt_load;
  logic [6:1] cy;
  bcd_t cs_o, cs_t, sec_o, sec_t, min_o, min_t;
  sw_time_t live, disp;

  assign tick  = sw.clk_100hz_in & ~prev_hz_q;
  assign clr_e = sw.btn_clear & ~prev_clr_q;
  assign ss_e  = sw.btn_start_stop & ~prev_ss_q & ~clr_e;
  assign lap_e = sw.btn_lap & ~prev_lap_q & ~clr_e & ~ss_e;

  assign live = '{min_t: min_t, min_o: min_o,
                  sec_t: sec_t, sec_o: sec_o,
                  cs_t:  cs_t,  cs_o:  cs_o};

  assign adv = tick & ((state_q == RUN) | (state_q == LAP));

  // cy[4]: cs/sec at 59.99; cy[6] catches a 99-minute top
  assign min_eq = ({min_t, min_o} ==
                   {tens_of(MAX_MIN), ones_of(MAX_MIN)});
  assign roll   = adv & ((cy[4] & min_eq) | cy[6]);

  assign cnt_clr  = clr_cnt | (roll & WRAP);
  assign cnt_load = roll & ~WRAP;

  bcd_digit_counter #(.MODULUS(10)) u_cs_o (
    .clk_in(clk_in), .rst_n(rst_n), .en(adv),
    .carry_in(1'b1), .clear(cnt_clr), .load_max(cnt_load),
    .q(cs_o), .carry_out(cy[1])
  );

  bcd_digit_counter #(
    .MODULUS(10), .MAX_Q(CS_MAX / 10)
  ) u_cs_t (
    .clk_in(clk_in), .rst_n(rst_n), .en(adv),
    .carry_in(cy[1]), .clear(cnt_clr), .load_max(cnt_load),
    .q(cs_t), .carry_out(cy[2])
  );

  bcd_digit_counter #(.MODULUS(10)) u_sec_o (
    .clk_in(clk_in), .rst_n(rst_n), .en(adv),
    .carry_in(cy[2]), .clear(cnt_clr), .load_max(cnt_load),
    .q(sec_o), .carry_out(cy[3])
  );

  bcd_digit_counter #(
    .MODULUS(SEC_MAX / 10 + 1)
  ) u_sec_t (
    .clk_in(clk_in), .rst_n(rst_n), .en(adv),
    .carry_in(cy[3]), .clear(cnt_clr), .load_max(cnt_load),
    .q(sec_t), .carry_out(cy[4])
  );

  bcd_digit_counter #(
    .MODULUS(10), .MAX_Q(MAX_MIN % 10)
  ) u_min_o (
    .clk_in(clk_in), .rst_n(rst_n), .en(adv),
    .carry_in(cy[4]), .clear(cnt_clr), .load_max(cnt_load),
    .q(min_o), .carry_out(cy[5])
  );

  bcd_digit_counter #(
    .MODULUS(10), .MAX_Q(MAX_MIN / 10)
  ) u_min_t (
    .clk_in(clk_in), .rst_n(rst_n), .en(adv),
    .carry_in(cy[5]), .clear(cnt_clr), .load_max(cnt_load),
    .q(min_t), .carry_out(cy[6])
  );

  always_comb begin
    state_d = state_q;
    lap_d   = lap_q;
    ovf_d   = ovf_q;
    clr_cnt = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (clr_e)     ovf_d   = 1'b0;
        else if (ss_e) state_d = RUN;
      end
      RUN: begin
        if (ss_e) begin
          state_d = PAUSE;
        end else if (lap_e) begin
          state_d = LAP;
          lap_d   = live;
        end
      end
      LAP: begin
        if (ss_e)       state_d = PAUSE;
        else if (lap_e) state_d = RUN;
      end
      PAUSE: begin
        if (clr_e) begin
          state_d = IDLE;
          clr_cnt = 1'b1;
          ovf_d   = 1'b0;
        end else if (ss_e) begin
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
    // saturation overrides any button action this cycle
    if (roll) begin
      ovf_d = 1'b1;
      if (!WRAP) state_d = PAUSE;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      lap_q      <= '0;
      ovf_q      <= 1'b0;
      prev_hz_q  <= 1'b0;
      prev_ss_q  <= 1'b0;
      prev_lap_q <= 1'b0;
      prev_clr_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lap_q      <= lap_d;
      ovf_q      <= ovf_d;
      prev_hz_q  <= sw.clk_100hz_in;
      prev_ss_q  <= sw.btn_start_stop;
      prev_lap_q <= sw.btn_lap;
      prev_clr_q <= sw.btn_clear;
    end
  end

  assign disp = (state_q == LAP) ? lap_q : live;

  assign sw.cs_ones    = disp.cs_o;
  assign sw.cs_tens    = disp.cs_t;
  assign sw.sec_ones   = disp.sec_o;
  assign sw.sec_tens   = disp.sec_t;
  assign sw.min_ones   = disp.min_o;
  assign sw.min_tens   = disp.min_t;
  assign sw.running    = (state_q == RUN) | (state_q == LAP);
  assign sw.lap_active = (state_q == LAP);
  assign sw.overflow   = ovf_q;

endmodule

// File: tb/tb_stopwatch_core.sv
// Bench for stopwatch_core: three configurations against a
// centisecond-count reference model, directed plus random buttons.
module tb_stopwatch_core;
  import stopwatch_pkg::*;

  localparam int S_IDLE  = 0;
  localparam int S_RUN   = 1;
  localparam int S_LAP   = 2;
  localparam int S_PAUSE = 3;

  typedef struct packed {
    int   cnt;
    int   lapv;
    int   st;
    logic ovf;
    logic phz;
    logic pss;
    logic plp;
    logic pcl;
  } model_t;

  logic clk_in = 1'b0;
  logic rst_n  = 1'b1;
  int   hzcnt  = 0;
  logic hz;
  logic bss [3];
  logic blp [3];
  logic bcl [3];
  logic [26:0] obs [3];
  model_t mdl [3];
  int total = 0;
  int bad   = 0;

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in)
    hzcnt <= (hzcnt == 9) ? 0 : hzcnt + 1;
  assign hz = (hzcnt < 5);

  stopwatch_if sw0 ();
  stopwatch_if sw1 ();
  stopwatch_if sw2 ();

  assign sw0.clk_100hz_in   = hz;
  assign sw0.btn_start_stop = bss[0];
  assign sw0.btn_lap        = blp[0];
  assign sw0.btn_clear      = bcl[0];
  assign sw1.clk_100hz_in   = hz;
  assign sw1.btn_start_stop = bss[1];
  assign sw1.btn_lap        = blp[1];
  assign sw1.btn_clear      = bcl[1];
  assign sw2.clk_100hz_in   = hz;
  assign sw2.btn_start_stop = bss[2];
  assign sw2.btn_lap        = blp[2];
  assign sw2.btn_clear      = bcl[2];

  stopwatch_core #(.MAX_MIN(59), .WRAP(1'b1)) u_dut0 (
    .clk_in(clk_in), .rst_n(rst_n), .sw(sw0)
  );
  stopwatch_core #(.MAX_MIN(0), .WRAP(1'b1)) u_dut1 (
    .clk_in(clk_in), .rst_n(rst_n), .sw(sw1)
  );
  stopwatch_core #(.MAX_MIN(0), .WRAP(1'b0)) u_dut2 (
    .clk_in(clk_in), .rst_n(rst_n), .sw(sw2)
  );

  assign obs[0] = {sw0.running, sw0.lap_active, sw0.overflow,
                   sw0.min_tens, sw0.min_ones, sw0.sec_tens,
                   sw0.sec_ones, sw0.cs_tens, sw0.cs_ones};
  assign obs[1] = {sw1.running, sw1.lap_active, sw1.overflow,
                   sw1.min_tens, sw1.min_ones, sw1.sec_tens,
                   sw1.sec_ones, sw1.cs_tens, sw1.cs_ones};
  assign obs[2] = {sw2.running, sw2.lap_active, sw2.overflow,
                   sw2.min_tens, sw2.min_ones, sw2.sec_tens,
                   sw2.sec_ones, sw2.cs_tens, sw2.cs_ones};

  function automatic int maxmin_of(int i);
    return (i == 0) ? 59 : 0;
  endfunction

  function automatic bit wrap_of(int i);
    return (i != 2);
  endfunction

  // Behavioural model: count held as total centiseconds
  function automatic model_t step(model_t m, logic h, logic s,
                                  logic l, logic c, int mm, bit wr);
    model_t n;
    int top;
    bit tk, ec, es, el, live;
    n   = m;
    top = (mm * 60 + 59) * 100 + 99;
    tk  = h && !m.phz;
    ec  = c && !m.pcl;
    es  = s && !m.pss && !ec;
    el  = l && !m.plp && !ec && !es;
    live = (m.st == S_RUN) || (m.st == S_LAP);
    n.phz = h;
    n.pss = s;
    n.plp = l;
    n.pcl = c;
    if (tk && live) begin
      if (m.cnt == top) begin
        n.ovf = 1'b1;
        if (wr) n.cnt = 0;
      end else begin
        n.cnt = m.cnt + 1;
      end
    end
    case (m.st)
      S_IDLE: begin
        if (ec) n.ovf = 1'b0;
        else if (es) n.st = S_RUN;
      end
      S_RUN: begin
        if (es) n.st = S_PAUSE;
        else if (el) begin
          n.st   = S_LAP;
          n.lapv = m.cnt;
        end
      end
      S_LAP: begin
        if (es) n.st = S_PAUSE;
        else if (el) n.st = S_RUN;
      end
      default: begin
        if (ec) begin
          n.st  = S_IDLE;
          n.cnt = 0;
          n.ovf = 1'b0;
        end else if (es) begin
          n.st = S_RUN;
        end
      end
    endcase
    if (tk && live && m.cnt == top && !wr) n.st = S_PAUSE;
    return n;
  endfunction

  function automatic logic [26:0] expect_of(model_t m);
    int v, mn, s, c;
    v  = (m.st == S_LAP) ? m.lapv : m.cnt;
    mn = v / 6000;
    s  = (v / 100) % 60;
    c  = v % 100;
    return {(m.st == S_RUN) || (m.st == S_LAP), m.st == S_LAP,
            m.ovf, 4'(mn / 10), 4'(mn % 10), 4'(s / 10),
            4'(s % 10), 4'(c / 10), 4'(c % 10)};
  endfunction

  always @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) mdl[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++)
        mdl[i] <= step(mdl[i], hz, bss[i], blp[i], bcl[i],
                       maxmin_of(i), wrap_of(i));
    end
  end

  // each iteration ends at the negedge where the next posedge samples hzcnt 5
  task automatic run_ticks(int n);
    repeat (n) begin
      @(negedge clk_in);
      while (hzcnt != 5) @(negedge clk_in);
    end
  endtask

  task automatic drive(int d, logic s, logic l, logic c);
    for (int i = 0; i < 3; i++) begin
      if (d == i || d == 3) begin
        bss[i] = s;
        blp[i] = l;
        bcl[i] = c;
      end
    end
  endtask

  task automatic press(int d, logic s, logic l, logic c);
    while (hzcnt != 5) @(negedge clk_in);
    drive(d, s, l, c);
    @(negedge clk_in);
    drive(d, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk_in);
    for (int i = 0; i < 3; i++) begin
      total++;
      if (obs[i] !== 27'd0) begin
        bad++;
        $display("FAIL reset[%0d] got=%h want=%h", i, obs[i], 27'd0);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_start();
    press(3, 1'b1, 1'b0, 1'b0);
    run_ticks(10);
    total++;
    if (obs[0] !== {3'b100, 24'h000010}) begin
      bad++;
      $display("FAIL start_10 got=%h want=%h", obs[0],
               {3'b100, 24'h000010});
    end
  endtask

  task automatic test_long_run();
    run_ticks(5990);
    total++;
    if (obs[0] !== {3'b100, 24'h010000}) begin
      bad++;
      $display("FAIL run_6000 got=%h want=%h", obs[0],
               {3'b100, 24'h010000});
    end
    total++;
    if (obs[1] !== {3'b101, 24'h000000}) begin
      bad++;
      $display("FAIL wrap_max0 got=%h want=%h", obs[1],
               {3'b101, 24'h000000});
    end
    total++;
    if (obs[2] !== {3'b001, 24'h005999}) begin
      bad++;
      $display("FAIL sat_max0 got=%h want=%h", obs[2],
               {3'b001, 24'h005999});
    end
  endtask

  task automatic test_pause();
    press(0, 1'b1, 1'b0, 1'b0);
    run_ticks(50);
    total++;
    if (obs[0] !== {3'b000, 24'h010000}) begin
      bad++;
      $display("FAIL pause_hold got=%h want=%h", obs[0],
               {3'b000, 24'h010000});
    end
  endtask

  task automatic test_clear_priority();
    press(0, 1'b1, 1'b0, 1'b1);
    run_ticks(3);
    total++;
    if (obs[0] !== 27'd0) begin
      bad++;
      $display("FAIL clear_wins got=%h want=%h", obs[0], 27'd0);
    end
  endtask

  task automatic test_lap();
    press(0, 1'b1, 1'b0, 1'b0);
    run_ticks(237);
    total++;
    if (obs[0] !== {3'b100, 24'h000237}) begin
      bad++;
      $display("FAIL lap_pre got=%h want=%h", obs[0],
               {3'b100, 24'h000237});
    end
    press(0, 1'b0, 1'b1, 1'b0);
    total++;
    if (obs[0] !== {3'b110, 24'h000237}) begin
      bad++;
      $display("FAIL lap_enter got=%h want=%h", obs[0],
               {3'b110, 24'h000237});
    end
    run_ticks(300);
    total++;
    if (obs[0] !== {3'b110, 24'h000237}) begin
      bad++;
      $display("FAIL lap_frozen got=%h want=%h", obs[0],
               {3'b110, 24'h000237});
    end
    press(0, 1'b0, 1'b1, 1'b0);
    total++;
    if (obs[0] !== {3'b100, 24'h000537}) begin
      bad++;
      $display("FAIL lap_release got=%h want=%h", obs[0],
               {3'b100, 24'h000537});
    end
  endtask

  task automatic test_clear_in_run();
    run_ticks(1);
    press(0, 1'b0, 1'b0, 1'b1);
    total++;
    if (obs[0] !== {3'b100, 24'h000538}) begin
      bad++;
      $display("FAIL clear_in_run got=%h want=%h", obs[0],
               {3'b100, 24'h000538});
    end
  endtask

  task automatic test_reset_mid();
    run_ticks(807);
    total++;
    if (obs[0] !== {3'b100, 24'h001345}) begin
      bad++;
      $display("FAIL pre_reset got=%h want=%h", obs[0],
               {3'b100, 24'h001345});
    end
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (obs[i] !== 27'd0) begin
        bad++;
        $display("FAIL async_rst[%0d] got=%h want=%h", i, obs[i],
                 27'd0);
      end
    end
    @(negedge clk_in);
    rst_n = 1'b1;
    run_ticks(1);
    total++;
    if (obs[0] !== 27'd0) begin
      bad++;
      $display("FAIL post_rst_tick got=%h want=%h", obs[0], 27'd0);
    end
  endtask

  task automatic test_held_button();
    bss[0] = 1'b1;
    repeat (40) @(negedge clk_in);
    total++;
    if (obs[0][26:25] !== 2'b10) begin
      bad++;
      $display("FAIL held_start got=%b want=%b", obs[0][26:25],
               2'b10);
    end
    bss[0] = 1'b0;
    repeat (20) @(negedge clk_in);
    total++;
    if (obs[0] !== expect_of(mdl[0]) || obs[0][26] !== 1'b1) begin
      bad++;
      $display("FAIL held_release got=%h want=%h", obs[0],
               expect_of(mdl[0]));
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk_in);
      for (int i = 0; i < 3; i++) begin
        total++;
        if (obs[i] !== expect_of(mdl[i])) begin
          bad++;
          $display("FAIL random[%0d] cyc=%0d got=%h want=%h", i, c,
                   obs[i], expect_of(mdl[i]));
        end
        if ($urandom_range(0, 11) == 0) bss[i] = ~bss[i];
        if ($urandom_range(0, 19) == 0) blp[i] = ~blp[i];
        if ($urandom_range(0, 39) == 0) bcl[i] = ~bcl[i];
      end
    end
    drive(3, 1'b0, 1'b0, 1'b0);
    @(negedge clk_in);
  endtask

  initial begin
    drive(3, 1'b0, 1'b0, 1'b0);
    #2;
    test_reset();
    test_start();
    test_long_run();
    test_pause();
    test_clear_priority();
    test_lap();
    test_clear_in_run();
    test_reset_mid();
    test_held_button();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
